divisor_restaurador: RTL and testbench

DIVISOR_RESTAURADOR -- requirements
Module: divisor_restaurador

---
 rtl/divisor_restaurador_pkg.sv | 9 +
 rtl/divisor_restaurador_controle.sv | 41 ++++
 rtl/divisor_restaurador.sv | 86 ++++++++
 tb/tb_divisor_restaurador.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/divisor_restaurador_pkg.sv
// Shared arithmetic constants for the serial multiplier and divider blocks.
// Operand width, frame length in clocks and the frame-counter width live here.
package divisor_restaurador_pkg;

    localparam int ARITH_N     = 16;
    localparam int ARITH_FRAME = 2 * ARITH_N;
    localparam int CNT_W       = 5;

endpackage

// File: rtl/divisor_restaurador_controle.sv
// Frame counter and step decode for the restoring divider: produces the
// load / subtract / shift strobes and marks the final subtract of a frame.
module controle_divisor
    import divisor_restaurador_pkg::*;
#(
    parameter int FRAME = ARITH_FRAME
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Sy,
    output logic load,
    output logic sub,
    output logic shift,
    output logic last
);

    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(FRAME - 1);

    logic [CNT_W-1:0] contador;

    // NOTE: sequential state is written with <= so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            contador <= '0;
        end else if (!Sy) begin
            contador <= '0;
        end else if (contador == ULTIMO) begin
            contador <= '0;
        end else begin
            contador <= contador + 1'b1;
        end
    end

    // Even nonzero counts shift, odd counts subtract, zero loads a new frame.
    assign load  = Sy && (contador == '0);
    assign sub   = Sy && contador[0];
    assign shift = Sy && !contador[0] && (contador != '0);
    assign last  = Sy && (contador == ULTIMO);

endmodule

// File: rtl/divisor_restaurador.sv
// Serial restoring divider: one subtract and one shift per bit, one result per
// 2*N-clock frame, framed by Sy. Datapath here, sequencing in controle_divisor.
module divisor_restaurador
    import divisor_restaurador_pkg::*;
#(
    parameter int N     = ARITH_N,
    parameter int FRAME = ARITH_FRAME
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Sy,
    input  logic [N-1:0] Dividendo,
    input  logic [N-1:0] Divisor,
    output logic [N-1:0] Quociente,
    output logic [N-1:0] Resto,
    output logic         DivZero,
    output logic         Pronto
);

    logic load, sub, shift, last;

    controle_divisor #(.FRAME(FRAME)) u_ctrl (
        .Clk   (Clk),
        .Reset (Reset),
        .Sy    (Sy),
        .load  (load),
        .sub   (sub),
        .shift (shift),
        .last  (last)
    );

    // w holds {partial remainder (N+1 bits), dividend bits / quotient bits}.
    logic [2*N:0]   w;
    logic [N-1:0]   divisor_reg;
    logic           divzero_reg;
    logic           frame_valid;

    logic [N:0]     diff;
    logic           ge;
    logic [2*N:0]   w_sub;

    always_comb begin
        diff  = w[2*N:N] - {1'b0, divisor_reg};
        ge    = w[2*N:N] >= {1'b0, divisor_reg};
        w_sub = ge ? {diff, w[N-1:1], 1'b1} : w;
    end

    // NOTE: every register, including the work register, is cleared by the
    // asynchronous reset so an aborted frame can never leak into a result.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            w           <= '0;
            divisor_reg <= '0;
            divzero_reg <= 1'b0;
            frame_valid <= 1'b0;
            Quociente   <= '0;
            Resto       <= '0;
            DivZero     <= 1'b0;
            Pronto      <= 1'b0;
        end else if (!Sy) begin
            w           <= '0;
            frame_valid <= 1'b0;
            Pronto      <= 1'b0;
        end else begin
            Pronto <= 1'b0;
            if (load) begin
                w           <= {{N{1'b0}}, Dividendo, 1'b0};
                divisor_reg <= Divisor;
                divzero_reg <= (Divisor == '0);
                frame_valid <= 1'b1;
            end else if (sub) begin
                w <= w_sub;
                // Results come from the post-subtract value of the final step.
                if (last && frame_valid) begin
                    Quociente <= w_sub[N-1:0];
                    Resto     <= w_sub[2*N-1:N];
                    DivZero   <= divzero_reg;
                    Pronto    <= 1'b1;
                end
            end else if (shift) begin
                w <= {w[2*N-1:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_divisor_restaurador.sv
// Directed bench for divisor_restaurador: table of back-to-back frames plus
// hand-written sequences for operand latching, Sy abort and reset abort.
module tb_divisor_restaurador;

    logic        Clk;
    logic        Reset;
    logic        Sy;
    logic [15:0] Dividendo;
    logic [15:0] Divisor;
    logic [15:0] Quociente;
    logic [15:0] Resto;
    logic        DivZero;
    logic        Pronto;

    int total  = 0;
    int passed = 0;

    divisor_restaurador dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Sy        (Sy),
        .Dividendo (Dividendo),
        .Divisor   (Divisor),
        .Quociente (Quociente),
        .Resto     (Resto),
        .DivZero   (DivZero),
        .Pronto    (Pronto)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Called at a negedge; the next posedge is the load edge. Leaves the bench
    // at the negedge right after the contador==31 edge.
    task automatic run_frame(input logic [15:0] a, input logic [15:0] b, input logic zero_after);
        int early;
        early     = 0;
        Dividendo = a;
        Divisor   = b;
        Sy        = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (k == 0) begin
                check("pronto_low_after_load", 32'(Pronto), 32'd0);
                if (zero_after) begin
                    Dividendo = '0;
                    Divisor   = '0;
                end
            end
            if (k < 31 && Pronto) early++;
        end
        check("pronto_not_early", 32'(early), 32'd0);
        check("pronto_at_31", 32'(Pronto), 32'd1);
    endtask

    // Starts a frame and stops at the negedge where contador == edges.
    task automatic run_partial(input logic [15:0] a, input logic [15:0] b, input int edges);
        int seen;
        seen      = 0;
        Dividendo = a;
        Divisor   = b;
        Sy        = 1'b1;
        for (int k = 0; k < edges; k++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (Pronto) seen++;
        end
        check("partial_no_pronto", 32'(seen), 32'd0);
    endtask

    task automatic check_out(input string tag, input logic [15:0] q, input logic [15:0] r, input logic dz);
        check({tag, "_q"},  32'(Quociente), 32'(q));
        check({tag, "_r"},  32'(Resto),     32'(r));
        check({tag, "_dz"}, 32'(DivZero),   32'(dz));
    endtask

    initial begin
        vecs[0] = '{16'd75,    16'd12,    16'd6,     16'd3,     1'b0};
        vecs[1] = '{16'hFFFF,  16'hFFFF,  16'd1,     16'd0,     1'b0};
        vecs[2] = '{16'hFFFF,  16'h0001,  16'hFFFF,  16'd0,     1'b0};
        vecs[3] = '{16'h1234,  16'h0000,  16'hFFFF,  16'h1234,  1'b1};
        vecs[4] = '{16'd7,     16'd9,     16'd0,     16'd7,     1'b0};
        vecs[5] = '{16'hFFFF,  16'h8000,  16'd1,     16'h7FFF,  1'b0};
        vecs[6] = '{16'd0,     16'd5,     16'd0,     16'd0,     1'b0};

        Reset     = 1'b0;
        Sy        = 1'b0;
        Dividendo = '0;
        Divisor   = '0;
        repeat (2) @(negedge Clk);
        check_out("reset", 16'd0, 16'd0, 1'b0);
        check("reset_pronto", 32'(Pronto), 32'd0);
        Reset = 1'b1;
        @(negedge Clk);

        // Back-to-back frames: Sy stays high, each result 32 clocks apart.
        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].a, vecs[i].b, 1'b0);
            check_out($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dz);
        end

        // Operands removed right after load: latched values must be used.
        run_frame(16'h0FA1, 16'h07D1, 1'b1);
        check_out("latched", 16'd1, 16'h07D0, 1'b0);

        // Pronto is one cycle wide and outputs hold while Sy is low.
        Sy = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        check("pronto_one_cycle", 32'(Pronto), 32'd0);
        repeat (3) @(negedge Clk);
        check_out("hold", 16'd1, 16'h07D0, 1'b0);

        // Sy dropped at contador==10.
        run_partial(16'd500, 16'd3, 10);
        Sy = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        check("sy_abort_cnt", 32'(dut.u_ctrl.contador), 32'd0);
        check("sy_abort_pronto", 32'(Pronto), 32'd0);
        check_out("sy_abort", 16'd1, 16'h07D0, 1'b0);
        run_frame(16'd100, 16'd7, 1'b0);
        check_out("after_sy_abort", 16'd14, 16'd2, 1'b0);

        // Reset asserted at contador==20.
        Sy = 1'b0;
        @(negedge Clk);
        run_partial(16'd50000, 16'd3, 20);
        Reset = 1'b0;
        #1;
        check("rst_abort_cnt", 32'(dut.u_ctrl.contador), 32'd0);
        check("rst_abort_pronto", 32'(Pronto), 32'd0);
        check_out("rst_abort", 16'd0, 16'd0, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;
        run_frame(16'd1000, 16'd33, 1'b0);
        check_out("after_rst_abort", 16'd30, 16'd10, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
